// File: rtl/array_counter_pkg.sv
// array_counter_pkg: shared mode enum and per-counter next-state result type
package array_counter_pkg;
  typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e;
  localparam int RES_W = 32;
  typedef struct packed {
    logic [RES_W-1:0] value;
    logic             ovf;
    logic             unf;
  } cnt_res_t;
endpackage

// File: rtl/array_counter_cell.sv
// array_counter_cell: combinational next value of one counter with net step, clear, wrap/saturate
module array_counter_cell
  import array_counter_pkg::*;
#(
  parameter int        W     = 6,
  parameter int        STEPW = 3,
  parameter cnt_mode_e MODE  = CNT_WRAP
) (
  input  logic [W-1:0]     cur,
  input  logic [STEPW-1:0] inc_amt,
  input  logic [STEPW-1:0] dec_amt,
  input  logic             clr,
  output logic [W-1:0]     nxt,
  output logic             ovf,
  output logic             unf
);
  logic signed [W+1:0] r;
  cnt_res_t            res;
  logic                unused_hi;
  always_comb begin
    r         = $signed({2'b00, cur}) + $signed((W+2)'(inc_amt)) - $signed((W+2)'(dec_amt));
    res.ovf   = !clr && !r[W+1] && r[W];
    res.unf   = !clr && r[W+1];
    res.value = RES_W'((clr || (res.unf && MODE == CNT_SAT)) ? '0 :
                       (res.ovf && MODE == CNT_SAT) ? {W{1'b1}} : r[W-1:0]);
  end
  assign nxt       = res.value[W-1:0];
  assign ovf       = res.ovf;
  assign unf       = res.unf;
  assign unused_hi = |res.value[RES_W-1:W];
endmodule

// File: rtl/array_counter_v2.sv
// array_counter_v2: bank of N addressed up/down counters; sticky error capture under ARRAY_COUNTER_ERR_EN
module array_counter_v2
  import array_counter_pkg::*;
#(
  parameter int W     = 6,
  parameter int N     = 8,
  parameter int STEPW = 3,
  parameter int SAT   = 0,
  parameter int IDW   = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic [IDW-1:0]      inc_id,
  input  logic [STEPW-1:0]    inc_step,
  input  logic                dec,
  input  logic [IDW-1:0]      dec_id,
  input  logic [STEPW-1:0]    dec_step,
  input  logic                clr,
  input  logic [IDW-1:0]      clr_id,
  input  logic [IDW-1:0]      rd_id,
  output logic [W-1:0]        rd_cnt,
  output logic [N-1:0][W-1:0] cnt,
  output logic [N-1:0]        zero,
  output logic                ovf_err,
  output logic                unf_err,
  output logic [IDW-1:0]      err_id,
  input  logic                err_clr
);
  localparam cnt_mode_e MODE = (SAT != 0) ? CNT_SAT : CNT_WRAP;
  logic [N-1:0][W-1:0] cnt_q, cnt_d;
  logic [W-1:0]        rd_cnt_q, rd_cnt_d;
  logic [N-1:0]        ovf_v, unf_v;
  for (genvar i = 0; i < N; i++) begin : g_cell
    array_counter_cell #(.W(W), .STEPW(STEPW), .MODE(MODE)) u_cell (
      .cur     (cnt_q[i]),
      .inc_amt ((inc && inc_id == IDW'(i)) ? inc_step : '0),
      .dec_amt ((dec && dec_id == IDW'(i)) ? dec_step : '0),
      .clr     (clr && clr_id == IDW'(i)),
      .nxt     (cnt_d[i]),
      .ovf     (ovf_v[i]),
      .unf     (unf_v[i])
    );
  end
  // read samples the pre-update value; ids past N read as zero
  always_comb rd_cnt_d = ({1'b0, rd_id} < (IDW+1)'(N)) ? cnt_q[rd_id] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      rd_cnt_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end
  always_comb for (int i = 0; i < N; i++) zero[i] = cnt_q[i] == '0;
  assign cnt    = cnt_q;
  assign rd_cnt = rd_cnt_q;
`ifdef ARRAY_COUNTER_ERR_EN
  logic           ovf_q, ovf_d, unf_q, unf_d;
  logic [IDW-1:0] err_id_q, err_id_d, ovf_id, unf_id;
  always_comb begin
    ovf_id = '0;
    unf_id = '0;
    for (int i = 0; i < N; i++) begin
      if (ovf_v[i]) ovf_id = IDW'(i);
      if (unf_v[i]) unf_id = IDW'(i);
    end
    ovf_d    = (ovf_q && !err_clr) || |ovf_v;
    unf_d    = (unf_q && !err_clr) || |unf_v;
    err_id_d = ((|ovf_v || |unf_v) && (err_clr || !(ovf_q || unf_q))) ?
               (|ovf_v ? ovf_id : unf_id) : err_id_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      err_id_q <= '0;
    end else begin
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      err_id_q <= err_id_d;
    end
  end
  assign ovf_err = ovf_q;
  assign unf_err = unf_q;
  assign err_id  = err_id_q;
`else
  logic [2*N:0] unused_err;
  assign unused_err = {err_clr, ovf_v, unf_v};
  assign ovf_err    = 1'b0;
  assign unf_err    = 1'b0;
  assign err_id     = '0;
`endif
endmodule

// File: tb/tb_array_counter_v2.sv
// tb_array_counter_v2: wrap and saturate instances driven in lockstep against an integer reference model
module tb_array_counter_v2;
  localparam int W = 6, N = 8, STEPW = 3, IDW = 3, MAXV = 63;
  logic clk = 1'b0;
  logic rst, inc, dec, clr, err_clr;
  logic [IDW-1:0] inc_id, dec_id, clr_id, rd_id;
  logic [STEPW-1:0] inc_step, dec_step;
  logic [N-1:0][W-1:0] cnt0, cnt1;
  logic [W-1:0] rd0, rd1;
  logic [N-1:0] z0, z1;
  logic o0, o1, u0, u1;
  logic [IDW-1:0] e0, e1;
  int checks = 0, errors = 0;
  int mc[2][N];
  int mrd[2], mid[2];
  bit mo[2], mu[2];
  typedef struct {
    bit inc; int inc_id, inc_step;
    bit dec; int dec_id, dec_step;
    bit clr; int clr_id;
    int chk_id, exp0, exp1;
  } vec_t;
  vec_t tv[7];

  always #5 clk = ~clk;

  array_counter_v2 #(.W(W), .N(N), .STEPW(STEPW), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .inc(inc), .inc_id(inc_id), .inc_step(inc_step),
    .dec(dec), .dec_id(dec_id), .dec_step(dec_step), .clr(clr), .clr_id(clr_id),
    .rd_id(rd_id), .rd_cnt(rd0), .cnt(cnt0), .zero(z0), .ovf_err(o0),
    .unf_err(u0), .err_id(e0), .err_clr(err_clr));
  array_counter_v2 #(.W(W), .N(N), .STEPW(STEPW), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .inc(inc), .inc_id(inc_id), .inc_step(inc_step),
    .dec(dec), .dec_id(dec_id), .dec_step(dec_step), .clr(clr), .clr_id(clr_id),
    .rd_id(rd_id), .rd_cnt(rd1), .cnt(cnt1), .zero(z1), .ovf_err(o1),
    .unf_err(u1), .err_id(e1), .err_clr(err_clr));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    int nc[N];
    bit evo, evu;
    int oid, uid, r;
    for (int s = 0; s < 2; s++) begin
      evo = 0; evu = 0; oid = 0; uid = 0;
      for (int i = 0; i < N; i++) begin
        r = mc[s][i] + ((inc && inc_id == i) ? int'(inc_step) : 0)
                     - ((dec && dec_id == i) ? int'(dec_step) : 0);
        if (clr && clr_id == i) nc[i] = 0;
        else if (r > MAXV) begin nc[i] = s ? MAXV : r - (MAXV + 1); evo = 1; oid = i; end
        else if (r < 0) begin nc[i] = s ? 0 : r + (MAXV + 1); evu = 1; uid = i; end
        else nc[i] = r;
      end
      if (rst) begin
        mc[s] = '{default: 0};
        mrd[s] = 0; mo[s] = 0; mu[s] = 0; mid[s] = 0;
      end else begin
        mrd[s] = mc[s][rd_id];
        mc[s] = nc;
`ifdef ARRAY_COUNTER_ERR_EN
        if ((evo || evu) && (err_clr || !(mo[s] || mu[s]))) mid[s] = evo ? oid : uid;
        mo[s] = (mo[s] && !err_clr) || evo;
        mu[s] = (mu[s] && !err_clr) || evu;
`endif
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] ez0, ez1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("wrap_cnt%0d", i), cnt0[i], mc[0][i]);
      chk($sformatf("sat_cnt%0d", i), cnt1[i], mc[1][i]);
      ez0[i] = mc[0][i] == 0;
      ez1[i] = mc[1][i] == 0;
    end
    chk("wrap_zero", z0, ez0);
    chk("sat_zero", z1, ez1);
    chk("wrap_rd", rd0, mrd[0]);
    chk("sat_rd", rd1, mrd[1]);
    chk("wrap_err", {o0, u0, e0}, {mo[0], mu[0], 3'(mid[0])});
    chk("sat_err", {o1, u1, e1}, {mo[1], mu[1], 3'(mid[1])});
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input bit i, input int iid, input int ist, input bit d,
                       input int did, input int dst, input bit c, input int cid);
    inc = i; inc_id = 3'(iid); inc_step = 3'(ist);
    dec = d; dec_id = 3'(did); dec_step = 3'(dst);
    clr = c; clr_id = 3'(cid);
  endtask

  task automatic do_reset();
    rst = 1; err_clr = 0; rd_id = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 0;
  endtask

  task automatic load(input int id, input int val);
    for (int k = 0; k < val / 7; k++) begin drive(1, id, 7, 0, 0, 0, 0, 0); tick(); end
    if (val % 7 != 0) begin drive(1, id, val % 7, 0, 0, 0, 0, 0); tick(); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    tv[0] = '{1, 3, 5, 1, 3, 2, 0, 0, 3, 3, 3};
    tv[1] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 63, 0};
    tv[2] = '{1, 0, 2, 0, 0, 0, 0, 0, 0, 1, 2};
    tv[3] = '{1, 0, 5, 1, 3, 1, 1, 0, 0, 0, 0};
    tv[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 3, 2, 2};
    tv[5] = '{1, 7, 0, 1, 7, 0, 0, 0, 7, 0, 0};
    tv[6] = '{0, 0, 0, 1, 3, 3, 0, 0, 3, 63, 0};
    do_reset();
    chk("reset_zero", z0, 8'hFF);
    for (int k = 0; k < 7; k++) begin
      drive(tv[k].inc, tv[k].inc_id, tv[k].inc_step, tv[k].dec, tv[k].dec_id,
            tv[k].dec_step, tv[k].clr, tv[k].clr_id);
      tick();
      chk($sformatf("vec%0d_wrap", k), cnt0[tv[k].chk_id], tv[k].exp0);
      chk($sformatf("vec%0d_sat", k), cnt1[tv[k].chk_id], tv[k].exp1);
    end
    // wrap on overflow then underflow; err_id keeps the first event
    do_reset();
    load(1, 62);
    drive(1, 1, 4, 0, 0, 0, 0, 0); tick();
    chk("wrap_ovf_val", cnt0[1], 2);
    chk("sat_ovf_val", cnt1[1], 63);
`ifdef ARRAY_COUNTER_ERR_EN
    chk("wrap_ovf_flag", {o0, e0}, {1'b1, 3'd1});
`endif
    drive(0, 0, 0, 1, 0, 1, 0, 0); tick();
    chk("wrap_unf_val", cnt0[0], 63);
`ifdef ARRAY_COUNTER_ERR_EN
    chk("wrap_unf_flag", {u0, e0}, {1'b1, 3'd1});
`endif
    do_reset();
    load(2, 61);
    drive(1, 2, 7, 0, 0, 0, 0, 0); tick();
    chk("sat_top", cnt1[2], 63);
    for (int k = 0; k < 10; k++) begin drive(0, 0, 0, 1, 2, 7, 0, 0); tick(); end
    chk("sat_bottom", cnt1[2], 0);
    do_reset();
    load(4, 10);
    load(5, 9);
    drive(1, 4, 3, 1, 5, 1, 1, 4); tick();
    chk("clr_pri4", cnt0[4], 0);
    chk("clr_pri5", cnt0[5], 8);
    chk("clr_noerr", {o0, u0}, 2'b00);
    do_reset();
    rd_id = 6;
    chk("rd_lat_init", rd0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(1, 6, 1, 0, 0, 0, 0, 0); tick();
      chk($sformatf("rd_lat%0d", k), rd0, k);
    end
    for (int k = 0; k < 5; k++) begin
      drive(1, $urandom_range(7), $urandom_range(7), 1, $urandom_range(7), $urandom_range(7), 0, 0);
      tick();
    end
    rst = 1; tick(); rst = 0;
    chk("rst_mid_zero", {z0, z1}, 16'hFFFF);
    chk("rst_mid_cnt", cnt0 | cnt1, 0);
    chk("rst_mid_err", {o0, u0, o1, u1}, 4'b0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    load(7, 60);
    drive(0, 0, 0, 1, 0, 1, 0, 0); tick();
    err_clr = 1;
    drive(1, 7, 7, 0, 0, 0, 0, 0); tick();
    err_clr = 0;
`ifdef ARRAY_COUNTER_ERR_EN
    chk("errclr_race", {o0, u0, e0}, {1'b1, 1'b0, 3'd7});
`else
    chk("err_tied", {o0, u0, e0}, 5'b0);
`endif
    for (int k = 0; k < 600; k++) begin
      rst = $urandom_range(63) == 0;
      err_clr = $urandom_range(15) == 0;
      rd_id = 3'($urandom_range(7));
      drive($urandom_range(3) != 0, $urandom_range(7), $urandom_range(7),
            $urandom_range(3) != 0, $urandom_range(7), $urandom_range(7),
            $urandom_range(3) == 0, $urandom_range(7));
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/array_counter_v2.md
# array_counter_v2

Parametrised bank of N independent W-bit up/down counters addressed by ID, for per-channel credit, occupancy and event accounting. Adds the following to the previous generation:
- multi-unit increment and decrement steps
- net arithmetic when increment and decrement hit the same counter
- selectable wrap or saturate mode
- addressed clear
- registered read port
- per-counter zero flags
- optional sticky overflow/underflow error capture

## Interface
- `W`, 6: counter width.
- `N`, 8: number of counters, ≥2.
- `STEPW`, 3: width of step inputs.
- `SAT`, 0: 0 = wrap modulo 2^W; 1 = saturate at 0 and 2^W−1.
- `IDW`, `$clog2(N)`: ID width. Derived; do not override.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `inc`  in  1  increment request.
- `inc_id`  in  IDW  increment target.
- `inc_step`  in  STEPW  increment amount; 0 is legal (no-op).
- `dec`  in  1  decrement request.
- `dec_id`  in  IDW  decrement target.
- `dec_step`  in  STEPW  decrement amount.
- `clr`  in  1  clear request.
- `clr_id`  in  IDW  clear target.
- `rd_id`  in  IDW  read address.
- `rd_cnt`  out  W  registered read data.
- `cnt`  out  W × [N]  all counter values, registered.
- `zero`  out  N  `zero[i]` = (`cnt[i]` == 0); combinational from `cnt`.
- `ovf_err`  out  1  sticky overflow.
- `unf_err`  out  1  sticky underflow.
- `err_id`  out  IDW  ID of first error event.
- `err_clr`  in  1  clears the error flags.

## Operation
- Every cycle, for each counter i:
  - d_i = (`inc` & `inc_id`==i ? `inc_step` : 0) − (`dec` & `dec_id`==i ? `dec_step` : 0).
  - Compute r_i = `cnt[i]` + d_i, signed, W+2 bits wide.
- Same-ID `inc`+`dec`: both steps are applied as the single net d_i. There is no inhibit; equal steps leave the counter unchanged.
- Overflow: r_i > 2^W−1.
  - SAT=0: `cnt[i]` ← r_i mod 2^W.
  - SAT=1: `cnt[i]` ← 2^W−1.
- Underflow: r_i < 0.
  - SAT=0: `cnt[i]` ← r_i mod 2^W.
  - SAT=1: `cnt[i]` ← 0.
- Clear: `clr` with `clr_id`==i forces `cnt[i]` ← 0. This overrides any inc/dec to the same ID in that cycle, and that ID raises no error that cycle.
- `rd_cnt` ← `cnt[rd_id]` as held before this edge's update. Read sees the old value.
- Out-of-range IDs (≥ N, non-power-of-2 N):
  - Requests addressing them are ignored and no counter changes.
  - A read returns 0.
- Reset values:
  - All `cnt` = 0 and `rd_cnt` = 0.
  - `zero` = all ones.
  - `ovf_err` = 0, `unf_err` = 0, `err_id` = 0.

## Timing
- Update latency is 1 cycle: a request at edge k is visible on `cnt` after edge k.
- Read latency is 1 cycle. To observe an update at edge k, set `rd_id` before edge k+1.
- `zero` follows `cnt` in the same cycle.
- Reset has priority over all requests, including `clr` and `err_clr`.
- Reset mid-stream discards in-flight requests and errors.
- No handshake: every request is accepted every cycle.
- Different IDs on `inc`, `dec` and `clr` update independently in the same cycle.

## Configuration
- `ARRAY_COUNTER_ERR_EN` defined:
  - `ovf_err` / `unf_err` set on any overflow or underflow event, in either SAT mode, and stay set until `err_clr` or `rst`.
  - `err_id` latches the counter ID of the first event while both flags are 0.
  - If overflow and underflow occur on different IDs in the same cycle, both flags set and `err_id` takes the overflow ID.
  - If `err_clr` and a new event coincide, the new event wins: the flag stays set and `err_id` takes the new ID.
- `ARRAY_COUNTER_ERR_EN` undefined:
  - The three error outputs are tied to 0.
  - `err_clr` is ignored and no error logic is synthesised.
- Counting behaviour is identical with and without the macro.

## Structure
- `array_counter_pkg` holds:
  - the `cnt_mode_e` typedef (CNT_WRAP, CNT_SAT), used for the SAT mapping;
  - the `cnt_res_t` struct {value, ovf, unf} returned by the per-counter next-state computation.
- Sub-module `array_counter_cell`:
  - one instance per counter via generate;
  - inputs: current value, inc/dec amounts, clear;
  - outputs: next value, ovf, unf, all combinational.
- Top level holds:
  - the `cnt` register array;
  - ID decode;
  - the read register;
  - error capture.

## Test plan
All scenarios use W=6, N=8, STEPW=3.

- **Net update:** reset, then `inc` id 3 step 5 and `dec` id 3 step 2 in the same cycle → `cnt[3]`=3, all other counters 0, `zero[3]`=0.
- **Wrap:** SAT=0, `cnt[1]`=62, `inc` id 1 step 4 → `cnt[1]`=2 and `ovf_err`=1, `err_id`=1 (macro on). Then `dec` id 0 step 1 → `cnt[0]`=63 and `unf_err`=1, `err_id` still 1.
- **Saturate:** SAT=1, `cnt[2]`=61, `inc` id 2 step 7 → `cnt[2]`=63. Then `dec` id 2 step 7 for 10 cycles → `cnt[2]`=0 and stays 0.
- **Clear priority:** `cnt[4]`=10, `clr` id 4 plus `inc` id 4 step 3 plus `dec` id 5 step 1 with `cnt[5]`=9 → `cnt[4]`=0, `cnt[5]`=8, no error.
- **Read latency:** `rd_id`=6 held while `inc` id 6 step 1 every cycle from 0 → `rd_cnt` sequence 0,0,1,2,3 (read returns the pre-update value).
- **Reset and error clear:** `rst` asserted mid-burst → next cycle all `cnt`=0, `zero`=8'hFF, error flags 0. Then `err_clr` coincident with a new overflow on id 7 → `ovf_err` stays 1, `err_id`=7.
